// File: rtl/sar_adc_controller.sv
// sar_adc_controller: drives a DAC and reads a comparator to convert, by linear ramp or SAR search,
// publishing a registered result with a one-cycle valid pulse.
module sar_adc_controller #(
  parameter int WIDTH = 8,
  parameter int SETTLE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             successive_approx,
  input  logic             comp_in,
  output logic [WIDTH-1:0] dac_code,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             busy
);
  localparam int BW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam int CW = $clog2(SETTLE_CYCLES);
  localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE_CYCLES - 1);
  localparam logic [BW-1:0] MSB_IDX = BW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);
  typedef enum logic [1:0] {IDLE, SETTLE, DECIDE, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] bit_i, bit_n;
  logic mode, mode_n;
  logic [WIDTH-1:0] code_n, result_n, trial;
  logic [1:0] sync;
  logic comp_s;
  assign comp_s = sync[1];
  assign busy = state == SETTLE || state == DECIDE;
  assign result_valid = state == DONE;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_i    <= '0;
      mode     <= 1'b0;
      dac_code <= '0;
      result   <= '0;
      sync     <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_i    <= bit_n;
      mode     <= mode_n;
      dac_code <= code_n;
      result   <= result_n;
      sync     <= {sync[0], comp_in};
    end
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bit_n    = bit_i;
    mode_n   = mode;
    code_n   = dac_code;
    result_n = result;
    trial    = dac_code;
    trial[bit_i] = comp_s;
    if (bit_i != '0) trial[bit_i - 1'b1] = 1'b1;
    case (state)
      IDLE: code_n = '0;
      SETTLE: begin
        state_n = cnt == '0 ? DECIDE : SETTLE;
        cnt_n   = cnt == '0 ? cnt : cnt - 1'b1;
      end
      DECIDE:
        if (mode) begin
          code_n   = trial;
          result_n = bit_i == '0 ? trial : result;
          state_n  = bit_i == '0 ? DONE : SETTLE;
          bit_n    = bit_i == '0 ? bit_i : bit_i - 1'b1;
          cnt_n    = CNT_INIT;
        end else if (!comp_s) begin
          result_n = dac_code == '0 ? '0 : dac_code - 1'b1;
          state_n  = DONE;
        end else if (&dac_code) begin
          // saturation is checked before the increment so the ramp never wraps
          result_n = dac_code;
          state_n  = DONE;
        end else begin
          code_n  = dac_code + 1'b1;
          cnt_n   = CNT_INIT;
          state_n = SETTLE;
        end
      default: ;
    endcase
    if (!enable && state != IDLE) begin
      state_n = IDLE;
      code_n  = '0;
    end else if (enable && (state == IDLE || state == DONE)) begin
      mode_n  = successive_approx;
      code_n  = successive_approx ? MSB : '0;
      bit_n   = MSB_IDX;
      cnt_n   = CNT_INIT;
      state_n = SETTLE;
    end
  end
endmodule

// File: tb/tb_sar_adc_controller.sv
// tb_sar_adc_controller: randomized checks of ramp and SAR conversions against an ideal-comparator model.
module tb_sar_adc_controller;
  localparam int W = 8;
  localparam int S = 4;
  logic clk = 0, reset = 1, enable = 0, successive_approx = 0;
  logic comp_in;
  logic [W-1:0] vin = '0;
  logic [W-1:0] dac_code, result;
  logic result_valid, busy;
  int total = 0, bad = 0;
  logic [W-1:0] trace[$], expq[$];
  sar_adc_controller #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .enable(enable), .successive_approx(successive_approx),
    .comp_in(comp_in), .dac_code(dac_code), .result(result),
    .result_valid(result_valid), .busy(busy)
  );
  always #5 clk = ~clk;
  assign comp_in = (vin >= dac_code);
  function automatic void build_expect(input logic [W-1:0] v, input logic sar);
    int lim;
    expq.delete();
    if (sar) begin
      for (int i = W - 1; i >= 0; i--) expq.push_back(W'(((int'(v) >> (i + 1)) << (i + 1)) | (1 << i)));
    end else begin
      lim = (v == {W{1'b1}}) ? (1 << W) - 1 : int'(v) + 1;
      for (int c = 0; c <= lim; c++) expq.push_back(W'(c));
    end
  endfunction
  function automatic bit trace_ok();
    if (trace.size() != expq.size()) return 0;
    foreach (expq[j]) if (trace[j] !== expq[j]) return 0;
    return 1;
  endfunction
  task automatic wait_valid(output bit ok, output int n);
    ok = 0;
    n = 0;
    trace.delete();
    while (!ok && n < 3000) begin
      @(negedge clk);
      n++;
      if (busy && (trace.size() == 0 || trace[$] !== dac_code)) trace.push_back(dac_code);
      if (result_valid) ok = 1;
    end
  endtask
  task automatic go_idle();
    @(negedge clk);
    enable = 0;
    repeat (3) @(negedge clk);
  endtask
  task automatic test_reset();
    int k;
    #1 reset = 0;
    #10;
    total++;
    if ({dac_code, result, result_valid, busy} !== '0) begin
      bad++;
      $display("FAIL reset_init got %h/%h/%b/%b want 0", dac_code, result, result_valid, busy);
    end
    @(negedge clk);
    reset = 1;
    successive_approx = 1;
    vin = W'($urandom);
    enable = 1;
    repeat ($urandom_range(3, 30)) @(negedge clk);
    #2 reset = 0;
    #1;
    total++;
    if ({dac_code, result, result_valid, busy} !== '0) begin
      bad++;
      $display("FAIL reset_async got %h/%h/%b/%b want 0", dac_code, result, result_valid, busy);
    end
    #4 reset = 1;
    k = 0;
    while (!busy && k < 10) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (!busy || dac_code !== 8'h80) begin
      bad++;
      $display("FAIL reset_restart got busy=%b code=%h want 1/80", busy, dac_code);
    end
    go_idle();
  endtask
  task automatic run_mode(input logic sar, input logic [W-1:0] fixed[$]);
    logic [W-1:0] vins[$];
    bit ok;
    int n;
    vins = fixed;
    repeat (3) vins.push_back(W'($urandom));
    successive_approx = sar;
    foreach (vins[k]) begin
      vin = vins[k];
      build_expect(vin, sar);
      enable = 1;
      wait_valid(ok, n);
      total++;
      if (!ok || n != expq.size() * (S + 1) + 1) begin
        bad++;
        $display("FAIL period mode=%b vin=%h got %0d cycles want %0d", sar, vin, n, expq.size() * (S + 1) + 1);
      end
      total++;
      if (result !== vin) begin
        bad++;
        $display("FAIL result mode=%b got %h want %h", sar, result, vin);
      end
      total++;
      if (!trace_ok()) begin
        bad++;
        $display("FAIL trace mode=%b vin=%h got %0d codes want %0d", sar, vin, trace.size(), expq.size());
      end
      total++;
      if (dac_code !== (sar ? vin : expq[$])) begin
        bad++;
        $display("FAIL done_code mode=%b got %h want %h", sar, dac_code, sar ? vin : expq[$]);
      end
    end
    @(negedge clk);
    total++;
    if (result_valid !== 1'b0) begin
      bad++;
      $display("FAIL pulse_width got %b want 0", result_valid);
    end
    go_idle();
  endtask
  task automatic test_sar();
    run_mode(1'b1, '{8'hA5, 8'h00, 8'hFF});
  endtask
  task automatic test_ramp();
    run_mode(1'b0, '{8'h10, 8'h00, 8'hFF});
  endtask
  task automatic test_abort();
    bit ok;
    int n, k, pulses;
    logic [W-1:0] prev;
    successive_approx = 1;
    prev = W'($urandom);
    vin = prev;
    enable = 1;
    wait_valid(ok, n);
    total++;
    if (!ok || result !== prev) begin
      bad++;
      $display("FAIL abort_pre got %h want %h", result, prev);
    end
    vin = ~prev;
    trace.delete();
    k = 0;
    while (trace.size() < 3 && k < 100) begin
      @(negedge clk);
      k++;
      if (busy && (trace.size() == 0 || trace[$] !== dac_code)) trace.push_back(dac_code);
    end
    total++;
    if (trace.size() != 3) begin
      bad++;
      $display("FAIL abort_reach got %0d trials want 3", trace.size());
    end
    repeat ($urandom_range(0, S)) @(negedge clk);
    enable = 0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || dac_code !== '0) begin
      bad++;
      $display("FAIL abort_idle got busy=%b code=%h want 0/00", busy, dac_code);
    end
    pulses = 0;
    repeat (60) begin
      @(negedge clk);
      if (result_valid) pulses++;
    end
    total++;
    if (pulses != 0 || result !== prev) begin
      bad++;
      $display("FAIL abort_hold got %0d pulses result=%h want 0/%h", pulses, result, prev);
    end
  endtask
  task automatic test_mode_change();
    bit ok;
    int n;
    vin = W'($urandom_range(0, 60));
    successive_approx = 1;
    build_expect(vin, 1'b1);
    enable = 1;
    fork
      wait_valid(ok, n);
      begin
        repeat (10) @(negedge clk);
        successive_approx = 0;
      end
    join
    total++;
    if (!ok || result !== vin || !trace_ok()) begin
      bad++;
      $display("FAIL mode_keep_sar got %h (%0d codes) want %h (%0d codes)", result, trace.size(), vin, expq.size());
    end
    build_expect(vin, 1'b0);
    fork
      wait_valid(ok, n);
      begin
        repeat (3) @(negedge clk);
        successive_approx = 1;
      end
    join
    total++;
    if (!ok || result !== vin || !trace_ok() || n != expq.size() * (S + 1) + 1) begin
      bad++;
      $display("FAIL mode_next_ramp got %h (%0d codes, %0d cyc) want %h (%0d codes)", result, trace.size(), n, vin, expq.size());
    end
    build_expect(vin, 1'b1);
    wait_valid(ok, n);
    total++;
    if (!ok || result !== vin || !trace_ok() || n != W * (S + 1) + 1) begin
      bad++;
      $display("FAIL mode_next_sar got %h (%0d codes, %0d cyc) want %h", result, trace.size(), n, vin);
    end
    go_idle();
  endtask
  initial begin
    test_reset();
    test_sar();
    test_ramp();
    test_abort();
    test_mode_change();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
